// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP add/sub result path.
package fpu_pkg;

  localparam int unsigned FP_W = 64;

  // Bit positions within an IEEE flag vector
  localparam int unsigned FLG_INV = 4;
  localparam int unsigned FLG_DZ  = 3;
  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  typedef logic [4:0] fp_flags_t;

  typedef enum logic {
    RUN  = 1'b0,
    TRAP = 1'b1
  } coll_state_t;

  typedef struct packed {
    logic [FP_W-1:0] data;
    fp_flags_t       flags;
    logic            db;
  } fp_result_t;

endpackage

// File: rtl/fpu_result_fifo.sv
// In-order synchronous FIFO of fp_result_t with a separate occupancy counter.
module fpu_result_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  fp_result_t               wr_entry,
  output fp_result_t               head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fp_result_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = empty ? '0 : mem[rd_ptr];

  // Storage write; contents need no reset because head is masked when empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Pointers wrap modulo DEPTH; occupancy tracked independently
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_result_collector.sv
// Collects FP add/sub results, forwards them in order to writeback,
// accumulates sticky IEEE flags and halts forwarding on enabled exceptions.
module fpu_result_collector
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   res_valid,
  output logic                   res_ready,
  input  logic [W-1:0]           res_data,
  input  logic [4:0]             res_flags,
  input  logic                   res_db,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic [W-1:0]           wb_data,
  output logic [4:0]             wb_flags,
  output logic                   wb_db,
  input  logic [4:0]             trap_en,
  input  logic                   flag_clr,
  output logic [4:0]             sticky_flags,
  output logic                   trap,
  output logic [4:0]             trap_cause,
  input  logic                   trap_ack,
  output logic [$clog2(DEPTH):0] count
);

  coll_state_t state, next_state;
  fp_flags_t   cause_next;
  fp_result_t  wr_entry;
  fp_result_t  head;
  logic        push, pop, full, empty;

  assign wr_entry = '{data: FP_W'(res_data), flags: res_flags, db: res_db};

  fpu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .pop      (pop),
    .wr_entry (wr_entry),
    .head     (head),
    .count    (count),
    .full     (full),
    .empty    (empty)
  );

  assign res_ready = ~full;
  assign push      = res_valid & res_ready;
  assign wb_valid  = ~empty & (state == RUN);
  assign pop       = wb_valid & wb_ready;
  assign wb_data   = head.data[W-1:0];
  assign wb_flags  = head.flags;
  assign wb_db     = head.db;
  assign trap      = (state == TRAP);

  // Sticky flags; a commit in the same cycle as a clear survives the clear
  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_flags <= '0;
    end else if (flag_clr) begin
      sticky_flags <= pop ? wb_flags : '0;
    end else if (pop) begin
      sticky_flags <= sticky_flags | wb_flags;
    end
  end

  // State and trap cause registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      trap_cause <= '0;
    end else begin
      state      <= next_state;
      trap_cause <= cause_next;
    end
  end

  // Next-state: trap on a committed result carrying an enabled flag
  always_comb begin
    next_state = state;
    cause_next = trap_cause;
    case (state)
      RUN: begin
        if (pop && ((wb_flags & trap_en) != '0)) begin
          next_state = TRAP;
          cause_next = wb_flags & trap_en;
        end
      end
      TRAP: begin
        if (trap_ack) begin
          next_state = RUN;
          cause_next = '0;
        end
      end
      default: next_state = RUN;
    endcase
  end

endmodule

// File: tb/tb_fpu_result_collector.sv
// Directed test bench for fpu_result_collector (DEPTH=4, W=64).
module tb_fpu_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        res_valid;
  logic        res_ready;
  logic [63:0] res_data;
  logic [4:0]  res_flags;
  logic        res_db;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] wb_data;
  logic [4:0]  wb_flags;
  logic        wb_db;
  logic [4:0]  trap_en;
  logic        flag_clr;
  logic [4:0]  sticky_flags;
  logic        trap;
  logic [4:0]  trap_cause;
  logic        trap_ack;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fpu_result_collector #(.DEPTH(4), .W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .res_db       (res_db),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_flags     (wb_flags),
    .wb_db        (wb_db),
    .trap_en      (trap_en),
    .flag_clr     (flag_clr),
    .sticky_flags (sticky_flags),
    .trap         (trap),
    .trap_cause   (trap_cause),
    .trap_ack     (trap_ack),
    .count        (count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [63:0] d, input logic [4:0] f, input logic db);
    res_valid = 1'b1;
    res_data  = d;
    res_flags = f;
    res_db    = db;
    step();
    res_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; res_valid = 1'b0; res_data = '0; res_flags = '0; res_db = 1'b0;
    wb_ready = 1'b0; trap_en = '0; flag_clr = 1'b0; trap_ack = 1'b0;
    step(); step();
    rst = 1'b0;

    check("rst_res_ready", 64'(res_ready), 64'd1);
    check("rst_wb_valid",  64'(wb_valid), 64'd0);
    check("rst_wb_data",   wb_data, 64'd0);
    check("rst_count",     64'(count), 64'd0);
    check("rst_sticky",    64'(sticky_flags), 64'd0);
    check("rst_trap",      64'(trap), 64'd0);
    check("rst_cause",     64'(trap_cause), 64'd0);

    // Single result, one-cycle latency, ignored ack in RUN
    wb_ready = 1'b1;
    trap_ack = 1'b1;
    push_one(64'h4022000000000000, 5'b00000, 1'b1);
    trap_ack = 1'b0;
    check("single_valid", 64'(wb_valid), 64'd1);
    check("single_data",  wb_data, 64'h4022000000000000);
    check("single_db",    64'(wb_db), 64'd1);
    check("single_count", 64'(count), 64'd1);
    check("ack_in_run",   64'(trap), 64'd0);
    step();
    check("single_drain", 64'(count), 64'd0);
    check("single_wbv0",  64'(wb_valid), 64'd0);
    check("single_sticky", 64'(sticky_flags), 64'd0);

    // Backpressure: fill four, fifth stalls, then drain in order
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(64'hA0 + 64'(i), 5'b0, 1'b0);
    check("full_count", 64'(count), 64'd4);
    check("full_ready", 64'(res_ready), 64'd0);
    push_one(64'hEE, 5'b0, 1'b0);
    check("stall_count", 64'(count), 64'd4);
    wb_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("drain_valid", 64'(wb_valid), 64'd1);
      check("drain_data",  wb_data, 64'hA0 + 64'(i));
      step();
    end
    check("drain_empty", 64'(count), 64'd0);

    // Simultaneous push and pop keeps count
    push_one(64'hB1, 5'b0, 1'b0);
    push_one(64'hB2, 5'b0, 1'b0);
    check("pushpop_count", 64'(count), 64'd1);
    check("pushpop_data",  wb_data, 64'hB2);
    step();
    check("pushpop_drain", 64'(count), 64'd0);

    // Full with concurrent pop: push still blocked
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(64'hC0 + 64'(i), 5'b0, 1'b0);
    wb_ready = 1'b1;
    push_one(64'hCF, 5'b0, 1'b0);
    check("full_pop_count", 64'(count), 64'd3);
    for (int i = 1; i < 4; i++) begin
      check("full_pop_data", wb_data, 64'hC0 + 64'(i));
      step();
    end
    check("full_pop_empty", 64'(count), 64'd0);

    // Sticky flag without trap
    push_one(64'h7FF0000000000000, 5'b00100, 1'b1);
    check("ovf_flags", 64'(wb_flags), 64'h04);
    step();
    check("ovf_sticky", 64'(sticky_flags), 64'h04);
    check("ovf_notrap", 64'(trap), 64'd0);

    // Clear colliding with a commit
    wb_ready = 1'b0;
    push_one(64'h3FF0000000000001, 5'b00001, 1'b1);
    flag_clr = 1'b1;
    wb_ready = 1'b1;
    step();
    flag_clr = 1'b0;
    check("clr_commit", 64'(sticky_flags), 64'h01);

    // Trap on invalid; trap_en changes during TRAP are ignored
    trap_en  = 5'b10000;
    wb_ready = 1'b0;
    push_one(64'h7FF8000000000000, 5'b10000, 1'b1);
    push_one(64'h4000000000000000, 5'b00000, 1'b1);
    wb_ready = 1'b1;
    check("trap_first", wb_data, 64'h7FF8000000000000);
    step();
    check("trap_set",    64'(trap), 64'd1);
    check("trap_cause",  64'(trap_cause), 64'h10);
    check("trap_wbv",    64'(wb_valid), 64'd0);
    check("trap_count",  64'(count), 64'd1);
    check("trap_sticky", 64'(sticky_flags), 64'h11);
    trap_en = 5'b00000;
    step();
    check("trap_hold",   64'(trap), 64'd1);
    check("trap_hold_c", 64'(trap_cause), 64'h10);
    trap_ack = 1'b1;
    step();
    trap_ack = 1'b0;
    check("ack_trap",  64'(trap), 64'd0);
    check("ack_cause", 64'(trap_cause), 64'd0);
    check("ack_wbv",   64'(wb_valid), 64'd1);
    check("ack_data",  wb_data, 64'h4000000000000000);
    step();
    check("ack_drain", 64'(count), 64'd0);

    // Trap, keep filling while trapped, then reset mid-run
    trap_en  = 5'b00010;
    wb_ready = 1'b0;
    push_one(64'h0000000000000001, 5'b00010, 1'b0);
    push_one(64'hD1, 5'b0, 1'b0);
    push_one(64'hD2, 5'b0, 1'b0);
    wb_ready = 1'b1;
    step();
    push_one(64'hD3, 5'b0, 1'b0);
    check("fill_trap",  64'(trap), 64'd1);
    check("fill_count", 64'(count), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_count",  64'(count), 64'd0);
    check("mid_wbv",    64'(wb_valid), 64'd0);
    check("mid_trap",   64'(trap), 64'd0);
    check("mid_cause",  64'(trap_cause), 64'd0);
    check("mid_sticky", 64'(sticky_flags), 64'd0);
    check("mid_ready",  64'(res_ready), 64'd1);
    check("mid_data",   wb_data, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
